// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte-wide RAM/ROM bus responder with status register and write counter
// Optional MEM_WAIT_STATE_EN inserts one rdy-low wait state on ROM reads.
module mem_responder #(
    parameter int         RAM_AW        = 11,
    parameter int         ROM_AW        = 12,
    parameter logic [7:0] UNMAPPED_DATA = 8'hFF,
    parameter logic [15:0] STATUS_ADDR  = 16'h0050
) (
    input  logic        ph0,
    input  logic        resetb,
    input  logic [15:0] address,
    input  logic [7:0]  data_out,
    input  logic        read_en,
    output logic [7:0]  data_in,
    output logic        rdy,
    output logic [7:0]  status,
    output logic        status_valid,
    output logic        rom_write_err,
    output logic [15:0] wr_count
);

    localparam int          RAM_SIZE = 1 << RAM_AW;
    localparam int          ROM_SIZE = 1 << ROM_AW;
    localparam logic [16:0] RAM_TOP  = 17'(RAM_SIZE);
    localparam logic [16:0] ROM_BASE = 17'h10000 - 17'(ROM_SIZE);

    logic [7:0] RAM [0:RAM_SIZE-1];
    logic [7:0] ROM [0:ROM_SIZE-1];

    logic        w_is_ram;
    logic        w_is_rom;
    logic        w_rd;
    logic        w_wr;
    logic [7:0]  w_rd_data;

    logic [7:0]  r_data_in;
    logic        r_rdy;
    logic [7:0]  r_status;
    logic        r_status_valid;
    logic        r_rom_write_err;
    logic [15:0] r_wr_count;

    // RAM wins the decode if the two regions are ever parameterised to overlap
    assign w_is_ram = {1'b0, address} < RAM_TOP;
    assign w_is_rom = !w_is_ram && ({1'b0, address} >= ROM_BASE);
    assign w_rd     = r_rdy && read_en;
    assign w_wr     = r_rdy && !read_en;

    always_comb begin
        w_rd_data = UNMAPPED_DATA;
        if (w_is_ram)
            w_rd_data = RAM[address[RAM_AW-1:0]];
        else if (w_is_rom)
            w_rd_data = ROM[address[ROM_AW-1:0]];
    end

`ifdef MEM_WAIT_STATE_EN
    typedef enum logic {IDLE, WAIT} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_rom_stall;
    logic [ROM_AW-1:0] r_rom_addr;

    always_ff @(posedge ph0 or negedge resetb) begin
        if (!resetb)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_rom_stall = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rd && w_is_rom) begin
                    w_rom_stall = 1'b1;
                    w_next      = WAIT;
                end
            end
            WAIT:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
`endif

    always_ff @(posedge ph0 or negedge resetb) begin
        if (!resetb) begin
            r_data_in       <= 8'h00;
            r_rdy           <= 1'b1;
            r_status        <= 8'h00;
            r_status_valid  <= 1'b0;
            r_rom_write_err <= 1'b0;
            r_wr_count      <= 16'h0000;
`ifdef MEM_WAIT_STATE_EN
            r_rom_addr      <= '0;
`endif
        end else begin
`ifdef MEM_WAIT_STATE_EN
            if (r_state == WAIT) begin
                r_data_in <= ROM[r_rom_addr];
                r_rdy     <= 1'b1;
            end else if (w_rom_stall) begin
                r_rom_addr <= address[ROM_AW-1:0];
                r_rdy      <= 1'b0;
            end else if (w_rd) begin
                r_data_in <= w_rd_data;
            end
`else
            r_rdy <= 1'b1;
            if (w_rd)
                r_data_in <= w_rd_data;
`endif
            if (w_wr) begin
                if (r_wr_count != 16'hFFFF)
                    r_wr_count <= r_wr_count + 16'd1;
                if (w_is_rom)
                    r_rom_write_err <= 1'b1;
                if (address == STATUS_ADDR) begin
                    r_status       <= data_out;
                    r_status_valid <= 1'b1;
                end
            end
        end
    end

    // Arrays are outside the reset domain so their contents survive resetb.
    // A ROM-space write re-stores the addressed byte, leaving the ROM unchanged.
    always_ff @(posedge ph0) begin
        if (w_wr && w_is_ram)
            RAM[address[RAM_AW-1:0]] <= data_out;
        else if (w_wr && w_is_rom)
            ROM[address[ROM_AW-1:0]] <= ROM[address[ROM_AW-1:0]];
    end

    assign data_in       = r_data_in;
    assign rdy           = r_rdy;
    assign status        = r_status;
    assign status_valid  = r_status_valid;
    assign rom_write_err = r_rom_write_err;
    assign wr_count      = r_wr_count;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder (default and MEM_WAIT_STATE_EN builds)
module tb_mem_responder;

    localparam int RAM_AW   = 11;
    localparam int ROM_AW   = 12;
    localparam int ROM_BASE = 65536 - (1 << ROM_AW);
`ifdef MEM_WAIT_STATE_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic        ph0      = 1'b0;
    logic        resetb   = 1'b1;
    logic [15:0] address  = 16'h0000;
    logic [7:0]  data_out = 8'h00;
    logic        read_en  = 1'b1;
    logic [7:0]  data_in;
    logic        rdy;
    logic [7:0]  status;
    logic        status_valid;
    logic        rom_write_err;
    logic [15:0] wr_count;

    mem_responder dut (
        .ph0           (ph0),
        .resetb        (resetb),
        .address       (address),
        .data_out      (data_out),
        .read_en       (read_en),
        .data_in       (data_in),
        .rdy           (rdy),
        .status        (status),
        .status_valid  (status_valid),
        .rom_write_err (rom_write_err),
        .wr_count      (wr_count)
    );

    always #5 ph0 = ~ph0;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  m_ram [0:(1<<RAM_AW)-1];
    logic [7:0]  m_rom [0:(1<<ROM_AW)-1];
    logic [7:0]  m_status = 8'h00;
    logic        m_sv     = 1'b0;
    logic        m_err    = 1'b0;
    logic [15:0] m_wc     = 16'h0000;
    logic [7:0]  m_din    = 8'h00;
    logic [7:0]  sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_ram(input logic [15:0] a);
        return int'(a) < (1 << RAM_AW);
    endfunction

    function automatic bit is_rom(input logic [15:0] a);
        return !is_ram(a) && int'(a) >= ROM_BASE;
    endfunction

    function automatic logic [7:0] mread(input logic [15:0] a);
        if (is_ram(a)) return m_ram[a[RAM_AW-1:0]];
        if (is_rom(a)) return m_rom[a[ROM_AW-1:0]];
        return 8'hFF;
    endfunction

    // Called at a falling edge with rdy=1; returns at a falling edge with rdy=1.
    task automatic rd(input logic [15:0] a, input string tag);
        int low;
        logic [7:0] e;
        low = 0;
        address = a;
        read_en = 1'b1;
        sb.push_back(mread(a));
        @(posedge ph0);
        @(negedge ph0);
        while (rdy !== 1'b1 && low < 8) begin
            low++;
            @(negedge ph0);
        end
        chk({tag, "_rdylow"}, low, (WAIT_EN && is_rom(a)) ? 1 : 0);
        e = sb.pop_front();
        chk(tag, {24'h0, data_in}, {24'h0, e});
        m_din = e;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input string tag);
        address  = a;
        data_out = d;
        read_en  = 1'b0;
        @(posedge ph0);
        @(negedge ph0);
        read_en = 1'b1;
        if (is_ram(a)) m_ram[a[RAM_AW-1:0]] = d;
        if (is_rom(a)) m_err = 1'b1;
        if (a == 16'h0050) begin
            m_status = d;
            m_sv     = 1'b1;
        end
        if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
        chk({tag, "_din_hold"}, {24'h0, data_in}, {24'h0, m_din});
        chk({tag, "_wrcnt"}, {16'h0, wr_count}, {16'h0, m_wc});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_din"},  {24'h0, data_in}, 32'h0);
        chk({tag, "_rdy"},  {31'h0, rdy}, 32'h1);
        chk({tag, "_stat"}, {24'h0, status}, 32'h0);
        chk({tag, "_sv"},   {31'h0, status_valid}, 32'h0);
        chk({tag, "_err"},  {31'h0, rom_write_err}, 32'h0);
        chk({tag, "_wc"},   {16'h0, wr_count}, 32'h0);
    endtask

    initial begin
        logic [7:0]  v;
        logic [15:0] a;

        for (int i = 0; i < (1 << RAM_AW); i++) begin
            v = 8'($urandom);
            dut.RAM[i] = v;
            m_ram[i]   = v;
        end
        for (int i = 0; i < (1 << ROM_AW); i++) begin
            v = 8'($urandom);
            dut.ROM[i] = v;
            m_rom[i]   = v;
        end
        dut.ROM[0]    = 8'hA5; m_rom[0]    = 8'hA5;
        dut.ROM[16]   = 8'h3C; m_rom[16]   = 8'h3C;
        dut.ROM[4092] = 8'h00; m_rom[4092] = 8'h00;
        dut.ROM[4093] = 8'hF0; m_rom[4093] = 8'hF0;
        dut.ROM[4095] = 8'h7E; m_rom[4095] = 8'h7E;

        #1 resetb = 1'b0;
        #1 chk_reset_outputs("por");
        @(negedge ph0);
        @(negedge ph0);
        resetb = 1'b1;

        rd(16'hFFFC, "rom_fffc");
        rd(16'hFFFD, "rom_fffd");

        wr(16'h0050, 8'h88, "wr_status");
        chk("status", {24'h0, status}, {24'h0, m_status});
        chk("status_valid", {31'h0, status_valid}, {31'h0, m_sv});
        chk("err_clear", {31'h0, rom_write_err}, {31'h0, m_err});
        rd(16'h0050, "rd_status_ram");

        wr(16'hF000, 8'h55, "wr_rom");
        chk("rom_err", {31'h0, rom_write_err}, {31'h0, m_err});
        rd(16'hF000, "rom_unchanged");
        rd(16'h4000, "unmapped");
        wr(16'h4000, 8'h12, "wr_unmapped");

        rd(16'hF010, "rom_f010");
        rd(16'h0010, "ram_0010");

        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom_range(0, (1 << RAM_AW) - 1));
            v = 8'($urandom);
            wr(a, v, $sformatf("ram_wr%0d", i));
            rd(a, $sformatf("ram_rd%0d", i));
        end

        rd(16'hFFFF, "rom_ffff");
        rd(16'h07FF, "ram_top");
        rd(16'h0800, "unmapped_low");
        rd(16'hEFFF, "unmapped_high");
        rd(16'hF000, "rom_base");

        // Reset mid-access: in wait-state builds this lands in WAIT with rdy low
        address = 16'hF010;
        read_en = 1'b1;
        @(posedge ph0);
        #2 resetb = 1'b0;
        #1 chk_reset_outputs("mid_rst");
        m_wc = 16'h0; m_sv = 1'b0; m_err = 1'b0; m_status = 8'h0; m_din = 8'h0;
        @(negedge ph0);
        resetb = 1'b1;
        rd(16'hF010, "post_rst_rom");
        rd(16'h0050, "ram_survives");

        address  = 16'h4000;
        data_out = 8'h00;
        read_en  = 1'b0;
        repeat (65537) @(posedge ph0);
        @(negedge ph0);
        read_en = 1'b1;
        m_wc = 16'hFFFF;
        chk("wc_sat", {16'h0, wr_count}, {16'h0, m_wc});
        wr(16'h4000, 8'h01, "wc_hold");
        chk("err_after_sat", {31'h0, rom_write_err}, {31'h0, m_err});
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
